instr_pipe_tracker: RTL
=======================

Name: instr_pipe_tracker

Overview:
Holds the in-flight instruction word and valid bit for every pipeline stage and advances them each cycle. It is the consumer of the hazard controller's stall signal and the producer of that controller's per-stage instruction array. On stall it holds decode and injects a bubble behind it. On flush it squashes the younger stages. It also exposes a fetch-side ready, a retire strobe and a stall watchdog.

Parameters:
PIPELINE_LENGTH, 4, number of tracked stages; index 0 = decode (youngest), PIPELINE_LENGTH-1 = last stage before retire.
FLUSH_DEPTH, 2, number of youngest stages squashed on flush; legal range 1..PIPELINE_LENGTH.
STALL_TIMEOUT, 64, consecutive stall cycles before the watchdog fires; must be ≥2.

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset, sampled on rising clk
in_instr  in  [31:2]  fetched instruction word (bits 1:0 implied 2'b11)
in_valid  in  1  fetch has a word this cycle
in_ready  out  1  tracker accepts in_instr this cycle
stall  in  1  RAW hazard stall from hazard controller
flush  in  1  taken branch/jump redirect from execute
instr  out  [31:2] x PIPELINE_LENGTH  per-stage instruction words, to hazard controller
stage_valid  out  PIPELINE_LENGTH  per-stage real-instruction flag
retire_valid  out  1  stage PIPELINE_LENGTH-1 holds a real instruction this cycle
retire_instr  out  [31:2]  word in stage PIPELINE_LENGTH-1
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- NOP = addi x0,x0,0; its [31:2] value is 30'h0000_0004. Bubbles carry NOP with valid=0.
- Reset (reset_n=0 at clk edge): all instr[i]=NOP, stage_valid=0, stall counter=0, stall_timeout=0. A reset asserted mid-stall or mid-flush overrides everything.
- in_ready = !stall | flush (combinational). Handshake: a word is consumed when in_valid & in_ready.
- The per-cycle update is decided in priority order: reset > flush > stall > normal.
- Normal (no stall, no flush):
  - stage[0] <= in_valid ? {in_instr,1} : {NOP,0}.
  - stage[i] <= stage[i-1] for i≥1.
  - The old last stage leaves.
- Stall (and no flush):
  - stage[0] holds.
  - stage[1] <= {NOP,0}.
  - stage[i] <= stage[i-1] for i≥2.
  - in_instr is not consumed.
  - With PIPELINE_LENGTH=1, stage[0] holds and nothing retires.
- Flush:
  - stage[i] <= {NOP,0} for i<FLUSH_DEPTH.
  - stage[i] <= stage[i-1] for i≥FLUSH_DEPTH.
  - The incoming in_instr is accepted and discarded as wrong-path.
  - Flush and stall in the same cycle resolve as flush.
- Retire: retire_valid = stage_valid[PIPELINE_LENGTH-1]; retire_instr = instr[PIPELINE_LENGTH-1]. Both are combinational from registers, so they have zero added latency.
- Latency: a word accepted at edge N appears at instr[0] after N and retires PIPELINE_LENGTH cycles after acceptance, plus one cycle per stall while it sits in stage 0.
- Watchdog counter (clog2(STALL_TIMEOUT+1) bits):
  - Increments each cycle stall=1 & flush=0.
  - Clears on any non-stall cycle or on flush.
  - Saturates at STALL_TIMEOUT.
  - stall_timeout sets the cycle after the counter reaches STALL_TIMEOUT and stays set until reset.
- stage_valid only ever changes by shifting, squashing or loading from in_valid; there is no other source of valid=1.

Optional Feature:
Macro INSTR_PIPE_TRACKER_PERF_EN.
- Defined:
  - Adds outputs perf_retired[31:0] (increments on retire_valid) and perf_stalls[31:0] (increments each stall cycle without flush).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - the opcode constants (LOAD, STORE, BRANCH, JALR, MISC_MEM, JAL, OP_IMM, OP, SYSTEM, AUIPC, LUI);
  - NOP_INSTR (30'h0000_0004);
  - a packed struct stage_t {logic [31:2] instr; logic valid;}.
- One sub-module, pipe_stage_reg: a single stage_t register with load/squash inputs and a synchronous active-low reset, instantiated PIPELINE_LENGTH times via generate.
- Watchdog and perf counters stay in the top module.

Test Plan:
- Reset then 4 cycles idle (in_valid=0) -> all instr=30'h4, stage_valid=4'b0000, retire_valid=0, in_ready=1.
- Stream words A,B,C,D on consecutive cycles, no stall -> A in instr[3] with retire_valid=1 on the 4th cycle after its acceptance; stage_valid=4'b1111.
- A in stage 0, stall=1 for 2 cycles -> instr[0]=A held, in_ready=0, stage_valid[1]=0 twice; B is not consumed until stall drops; A retires 2 cycles later than in the no-stall case.
- Pipeline full with A..D, flush=1 together with stall=1 (FLUSH_DEPTH=2) -> next cycle stages 0,1 are NOP/invalid, stages 2,3 hold C,B shifted from 1,2; the incoming word is dropped; in_ready=1 during flush.
- Hold stall=1 for 64 cycles -> stall_timeout rises on cycle 65; drop stall -> flag stays 1; reset_n=0 one cycle -> flag 0.
- With INSTR_PIPE_TRACKER_PERF_EN: retire 10 instructions across 3 stall cycles -> perf_retired=10, perf_stalls=3; reset mid-run -> both 0 next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: RV32 opcodes, the canonical NOP word and the
// per-stage pipeline record used by the instruction tracker.
package core_pkg;

    typedef enum logic [6:0] {
        LOAD     = 7'b0000011,
        STORE    = 7'b0100011,
        BRANCH   = 7'b1100011,
        JALR     = 7'b1100111,
        MISC_MEM = 7'b0001111,
        JAL      = 7'b1101111,
        OP_IMM   = 7'b0010011,
        OP       = 7'b0110011,
        SYSTEM   = 7'b1110011,
        AUIPC    = 7'b0010111,
        LUI      = 7'b0110111
    } opcode_t;

    // addi x0,x0,0 with the always-11 low bits dropped
    localparam logic [31:2] NOP_INSTR = 30'h0000_0004;

    typedef struct packed {
        logic [31:2] instr;
        logic        valid;
    } stage_t;

    localparam stage_t BUBBLE = '{instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: holds a stage_t, loads a new one, or is squashed to a bubble.
module pipe_stage_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   load,
    input  logic   squash,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk) begin
        if (!reset_n)    q <= BUBBLE;
        else if (squash) q <= BUBBLE;
        else if (load)   q <= d;
    end

endmodule

// File: rtl/instr_pipe_tracker.sv
// Tracks the in-flight instruction per stage with stall/flush handling and a
// stall watchdog. Define INSTR_PIPE_TRACKER_PERF_EN for retire/stall counters.
module instr_pipe_tracker
    import core_pkg::*;
#(
    parameter int PIPELINE_LENGTH = 4,
    parameter int FLUSH_DEPTH     = 2,
    parameter int STALL_TIMEOUT   = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [31:2]                      in_instr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             stall,
    input  logic                             flush,
    output logic [PIPELINE_LENGTH-1:0][31:2] instr,
    output logic [PIPELINE_LENGTH-1:0]       stage_valid,
    output logic                             retire_valid,
    output logic [31:2]                      retire_instr,
    output logic                             stall_timeout
`ifdef INSTR_PIPE_TRACKER_PERF_EN
    ,
    output logic [31:0]                      perf_retired,
    output logic [31:0]                      perf_stalls
`endif
);

    localparam int CW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STALL_TIMEOUT);

    stage_t [PIPELINE_LENGTH-1:0] st;
    stage_t [PIPELINE_LENGTH-1:0] d;
    logic   [PIPELINE_LENGTH-1:0] load;
    logic   [PIPELINE_LENGTH-1:0] squash;

    logic stall_only;
    assign stall_only = stall & ~flush;

    // A flush redirects fetch, so the wrong-path word is taken and dropped.
    assign in_ready = ~stall | flush;

    genvar g;
    generate
        for (g = 0; g < PIPELINE_LENGTH; g++) begin : g_stage
            localparam bit IN_FLUSH = (g < FLUSH_DEPTH);
            if (g == 0) begin : g_head
                assign d[g]      = '{instr: in_instr, valid: 1'b1};
                assign load[g]   = ~stall;
                assign squash[g] = (IN_FLUSH & flush) | (~stall & ~in_valid);
            end else if (g == 1) begin : g_bubble
                // Decode holds on stall, so the slot behind it becomes a bubble.
                assign d[g]      = st[g-1];
                assign load[g]   = 1'b1;
                assign squash[g] = (IN_FLUSH & flush) | stall_only;
            end else begin : g_tail
                assign d[g]      = st[g-1];
                assign load[g]   = 1'b1;
                assign squash[g] = IN_FLUSH & flush;
            end

            pipe_stage_reg u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (load[g]),
                .squash  (squash[g]),
                .d       (d[g]),
                .q       (st[g])
            );

            assign instr[g]       = st[g].instr;
            assign stage_valid[g] = st[g].valid;
        end
    endgenerate

    assign retire_valid = st[PIPELINE_LENGTH-1].valid;
    assign retire_instr = st[PIPELINE_LENGTH-1].instr;

    logic [CW-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stall_only)            stall_cnt <= '0;
            else if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == CNT_MAX)   stall_timeout <= 1'b1;
        end
    end

`ifdef INSTR_PIPE_TRACKER_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_retired <= '0;
            perf_stalls  <= '0;
        end else begin
            if (retire_valid) perf_retired <= perf_retired + 32'd1;
            if (stall_only)   perf_stalls  <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
